conv_task_sequencer: RTL and testbench

- Autonomous command sequencer for the conv accelerator control registers. Replaces per-phase AXI-lite programming by the host.
- Accepts 128-bit task descriptors into a small on-chip queue. Each descriptor holds four 32-bit words, {reg_3, reg_2, reg_1, reg_0}.
- Drives reg_0..reg_3 into the accelerator one task at a time, waits for ap_done, then deasserts the enable bits before issuing the next task.
- Sits between the host-facing descriptor interface and the accelerator register inputs; it is a drop-in replacement for the AXI-lite register outputs.

---
 rtl/conv_seq_pkg.sv | 46 ++++
 rtl/seq_desc_fifo.sv | 53 +++++
 rtl/conv_task_sequencer.sv | 166 ++++++++++++++++
 tb/tb_conv_task_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared definitions for the conv task sequencer: FSM encoding, reg_0 bit
// positions of the enable mask and EOL flag, and descriptor field offsets.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_ERR   = 3'd5
  } seq_state_t;

  // reg_0 enable bits that start the accelerator phases
  localparam int BIT_RECV_EN    = 0;
  localparam int BIT_SEND_EN    = 1;
  localparam int BIT_CONV_START = 4;
  localparam int BIT_TASK_VALID = 9;
  // end-of-list marker carried in the descriptor, never forwarded
  localparam int BIT_EOL        = 23;

  localparam logic [31:0] ENABLE_MASK = (32'd1 << BIT_RECV_EN)
                                      | (32'd1 << BIT_SEND_EN)
                                      | (32'd1 << BIT_CONV_START)
                                      | (32'd1 << BIT_TASK_VALID);
  localparam logic [31:0] EOL_MASK    = 32'd1 << BIT_EOL;

  // descriptor layout {reg_3, reg_2, reg_1, reg_0}
  localparam int REG_W    = 32;
  localparam int DESC_W   = 4 * REG_W;
  localparam int REG0_LSB = 0;
  localparam int REG1_LSB = 32;
  localparam int REG2_LSB = 64;
  localparam int REG3_LSB = 96;

  // reg_0 as driven while a task runs: EOL stripped
  function automatic logic [31:0] strip_eol(input logic [31:0] r);
    return r & ~EOL_MASK;
  endfunction

  // reg_0 as driven while no task runs: enables and EOL forced low
  function automatic logic [31:0] mask_enables(input logic [31:0] r);
    return r & ~(ENABLE_MASK | EOL_MASK);
  endfunction

endpackage

// File: rtl/seq_desc_fifo.sv
// Descriptor queue: synchronous FIFO, registered (non fall-through) read
// port, flush clears occupancy. Storage has no reset so it maps to LUT RAM.
module seq_desc_fifo
  import conv_seq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int PTR_BIT = 3,
  parameter int WIDTH   = DESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [WIDTH-1:0]   pop_data,
  output logic [PTR_BIT:0]   level
);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_BIT-1:0] wr_ptr;
  logic [PTR_BIT-1:0] rd_ptr;

  // storage write, no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // pointers and occupancy; flush drops every entry at once
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BIT'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BIT'(1);
      case ({push, pop})
        2'b10:   level <= level + (PTR_BIT+1)'(1);
        2'b01:   level <= level - (PTR_BIT+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // head register: updated only on pop, survives flush so the last task's
  // register values stay visible on the outputs
  always_ff @(posedge clk) begin
    if (rst)               pop_data <= '0;
    else if (pop && !flush) pop_data <= mem[rd_ptr];
  end

endmodule

// File: rtl/conv_task_sequencer.sv
// Autonomous sequencer that feeds queued 128-bit task descriptors into the
// conv accelerator registers, one task per ap_done, with an enable-low gap
// between tasks, a WAIT timeout and abort/flush.
//
// Descriptor handshake: a descriptor transfers on a rising clk edge where
// desc_valid and desc_ready are both high; desc_ready depends only on
// registered state, never on desc_valid. An abort in the same cycle discards
// the transfer.
module conv_task_sequencer
  import conv_seq_pkg::*;
#(
  parameter int DESC_DEPTH     = 8,
  parameter int DESC_PTR_BIT   = 3,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TIMEOUT_BIT    = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    desc_valid,
  output logic                    desc_ready,
  input  logic [DESC_W-1:0]       desc_data,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    ap_done,
  output logic [REG_W-1:0]        reg_0,
  output logic [REG_W-1:0]        reg_1,
  output logic [REG_W-1:0]        reg_2,
  output logic [REG_W-1:0]        reg_3,
  output logic                    busy,
  output logic                    list_done,
  output logic                    timeout_err,
  output logic [15:0]             task_count,
  output logic [DESC_PTR_BIT:0]   fifo_level
);

  localparam int LEVEL_W = DESC_PTR_BIT + 1;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  seq_state_t             state;
  seq_state_t             state_next;
  logic [DESC_W-1:0]      desc;
  logic [LEVEL_W-1:0]     level;
  logic [TIMEOUT_BIT-1:0] tmo_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   aborting;
  logic                   list_done_q;
  logic [15:0]            task_count_q;
  logic                   push;
  logic                   pop;
  logic                   eol;
  logic                   gap_last;
  logic                   tmo_last;
  logic                   queue_empty;

  // a pop slot frees one entry, so a full queue still accepts in POP
  assign desc_ready  = (level < LEVEL_W'(DESC_DEPTH)) || (state == ST_POP);
  assign push        = desc_valid && desc_ready && !abort;
  assign pop         = (state == ST_POP) && !abort;
  assign queue_empty = (level == '0);
  assign eol         = desc[REG0_LSB + BIT_EOL];
  assign gap_last    = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign tmo_last    = (tmo_cnt == TIMEOUT_BIT'(TIMEOUT_CYCLES - 1));

  seq_desc_fifo #(
    .DEPTH   (DESC_DEPTH),
    .PTR_BIT (DESC_PTR_BIT),
    .WIDTH   (DESC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (desc_data),
    .pop       (pop),
    .flush     (abort),
    .pop_data  (desc),
    .level     (level)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // next-state logic; abort outranks everything except the ERR exit
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (abort)                      state_next = ST_GAP;
        else if (start && !queue_empty) state_next = ST_POP;
      end
      ST_POP: begin
        if (abort) state_next = ST_GAP;
        else       state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (abort) state_next = ST_GAP;
        else       state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (abort || ap_done) state_next = ST_GAP;
        else if (tmo_last)    state_next = ST_ERR;
      end
      ST_GAP: begin
        if (abort)                  state_next = ST_GAP;
        else if (gap_last) begin
          if (aborting || eol)      state_next = ST_IDLE;
          else if (!queue_empty)    state_next = ST_POP;
          else                      state_next = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (abort) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // counters, abort marker, task count and list_done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt      <= '0;
      gap_cnt      <= '0;
      aborting     <= 1'b0;
      list_done_q  <= 1'b0;
      task_count_q <= '0;
    end else begin
      list_done_q <= (state == ST_GAP) && gap_last && !abort && !aborting && eol;

      if (state == ST_ISSUE)     tmo_cnt <= '0;
      else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + TIMEOUT_BIT'(1);

      // a fresh GAP (or an abort during GAP) restarts the gap length
      if (state_next == ST_GAP && (state != ST_GAP || abort)) gap_cnt <= '0;
      else if (state == ST_GAP)                               gap_cnt <= gap_cnt + GAP_W'(1);

      if (abort && state != ST_ERR)        aborting <= 1'b1;
      else if (state == ST_GAP && gap_last) aborting <= 1'b0;

      if (state == ST_IDLE && start && !queue_empty && !abort)
        task_count_q <= '0;
      else if (state == ST_WAIT && ap_done && !abort)
        task_count_q <= task_count_q + 16'd1;
    end
  end

  // outputs: enables only live while the task is issued and running
  always_comb begin
    reg_1       = desc[REG1_LSB +: REG_W];
    reg_2       = desc[REG2_LSB +: REG_W];
    reg_3       = desc[REG3_LSB +: REG_W];
    if (state == ST_ISSUE || state == ST_WAIT)
      reg_0 = strip_eol(desc[REG0_LSB +: REG_W]);
    else
      reg_0 = mask_enables(desc[REG0_LSB +: REG_W]);
    busy        = (state == ST_POP) || (state == ST_ISSUE) ||
                  (state == ST_WAIT) || (state == ST_GAP);
    timeout_err = (state == ST_ERR);
    list_done   = list_done_q;
    task_count  = task_count_q;
    fifo_level  = level;
  end

endmodule

// File: tb/tb_conv_task_sequencer.sv
// Directed bench for conv_task_sequencer: single list with EOL, full queue,
// stale done, abort, underrun, timeout and reset mid-task.
module tb_conv_task_sequencer;

  localparam int DEPTH   = 8;
  localparam int PTR     = 3;
  localparam int GAP     = 4;
  localparam int TMO     = 64;
  localparam int TMO_BIT = 7;
  localparam logic [31:0] EN_MASK  = 32'h0000_0213;
  localparam logic [31:0] EOL_BIT  = 32'h0080_0000;

  logic         clk;
  logic         rst;
  logic         desc_valid;
  logic         desc_ready;
  logic [127:0] desc_data;
  logic         start;
  logic         abort;
  logic         ap_done;
  logic [31:0]  reg_0, reg_1, reg_2, reg_3;
  logic         busy;
  logic         list_done;
  logic         timeout_err;
  logic [15:0]  task_count;
  logic [PTR:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int ld_cnt = 0;
  logic [127:0] exp_q[$];

  conv_task_sequencer #(
    .DESC_DEPTH     (DEPTH),
    .DESC_PTR_BIT   (PTR),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_BIT    (TMO_BIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .desc_valid  (desc_valid),
    .desc_ready  (desc_ready),
    .desc_data   (desc_data),
    .start       (start),
    .abort       (abort),
    .ap_done     (ap_done),
    .reg_0       (reg_0),
    .reg_1       (reg_1),
    .reg_2       (reg_2),
    .reg_3       (reg_3),
    .busy        (busy),
    .list_done   (list_done),
    .timeout_err (timeout_err),
    .task_count  (task_count),
    .fifo_level  (fifo_level)
  );

  // clock and list_done pulse monitor
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && list_done) ld_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input logic [31:0] r0, input int k);
    return {32'hC000_0000 | 32'(k), 32'hB000_0000 | 32'(k), 32'hA000_0000 | 32'(k), r0};
  endfunction

  task automatic push_desc(input logic [127:0] d);
    desc_valid = 1'b1;
    desc_data  = d;
    check("push_ready", desc_ready, 1);
    tick();
    desc_valid = 1'b0;
    exp_q.push_back({d[127:32], d[31:0] & ~EOL_BIT});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // current cycle is ISSUE: registers must show the queue head
  task automatic check_issue(input string tag);
    logic [127:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {reg_3, reg_2, reg_1, reg_0}, e);
      check({tag, "_busy"}, busy, 1);
    end
  endtask

  // ap_done in WAIT cycle 'after' counted from ISSUE; returns in GAP cycle 1
  task automatic answer_done(input int after);
    repeat (after) tick();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
  endtask

  // cycles with enables low from here until the next ISSUE (bounded)
  task automatic count_low(output int n);
    n = 0;
    while ((reg_0 & EN_MASK) == 0 && n < 20) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; desc_valid = 1'b0; desc_data = '0;
    start = 1'b0; abort = 1'b0; ap_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_reg0", reg_0, 0);
    check("rst_ready", desc_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_busy", busy, 0);
    check("rst_tcount", task_count, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_ldone", list_done, 0);

    // three-task list, EOL on the last
    push_desc(mk(32'h0D00_0211, 1));
    push_desc(mk(32'h0D00_0211, 2));
    push_desc(mk(32'h0D80_0211, 3));
    check("l1_level", fifo_level, 3);
    pulse_start();
    check("l1_pop_busy", busy, 1);
    check("l1_pop_reg0", reg_0, 0);
    tick();
    check_issue("l1_issue0");
    for (int t = 0; t < 3; t++) begin
      answer_done(10);
      check("l1_tcount", task_count, 16'(t + 1));
      check("l1_gap_reg0", reg_0, 32'h0D00_0000);
      if (t < 2) begin
        // GAP plus the POP slot keep the enables low
        count_low(n);
        check("l1_low_cycles", n, GAP + 1);
        check_issue("l1_issue");
      end else begin
        repeat (GAP - 1) tick();
        check("l1_last_gap_busy", busy, 1);
        tick();
        check("l1_idle_busy", busy, 0);
        check("l1_ldone", list_done, 1);
        tick();
        check("l1_ldone_once", list_done, 0);
      end
    end
    check("l1_ld_cnt", ld_cnt, 1);
    check("l1_final_tcount", task_count, 3);
    check("l1_idle_reg0", reg_0, 32'h0D00_0000);

    // full queue: 8 accepted, 9th held until the POP slot
    for (int k = 0; k < DEPTH; k++) push_desc(mk(32'h0000_0213 | 32'(k << 12), 10 + k));
    check("full_ready", desc_ready, 0);
    check("full_level", fifo_level, 8);
    desc_valid = 1'b1;
    desc_data  = mk(32'h0000_0213, 99);
    tick();
    check("full_held", fifo_level, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("full_pop_ready", desc_ready, 1);
    tick();
    desc_valid = 1'b0;
    exp_q.push_back(mk(32'h0000_0213, 99));
    check("full_pushpop_level", fifo_level, 8);
    check("full_tcount_clr", task_count, 0);
    check_issue("full_issue");

    // ap_done during ISSUE is stale
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    check("stale_tcount", task_count, 0);
    repeat (5) tick();
    check("stale_busy", busy, 1);
    check("stale_en_high", (reg_0 & EN_MASK) != 0, 1);

    // abort together with ap_done in WAIT
    abort = 1'b1;
    ap_done = 1'b1;
    tick();
    abort = 1'b0;
    ap_done = 1'b0;
    exp_q.delete();
    check("abort_level", fifo_level, 0);
    check("abort_tcount", task_count, 0);
    check("abort_gap_busy", busy, 1);
    check("abort_en_low", reg_0 & EN_MASK, 0);
    repeat (GAP - 1) tick();
    check("abort_gap_end_busy", busy, 1);
    tick();
    check("abort_idle_busy", busy, 0);
    check("abort_no_ldone", ld_cnt, 1);

    // abort coinciding with a push discards the push
    desc_valid = 1'b1;
    desc_data  = mk(32'h0000_0213, 50);
    abort = 1'b1;
    tick();
    desc_valid = 1'b0;
    abort = 1'b0;
    check("abort_push_level", fifo_level, 0);
    check("abort_idle_gap", busy, 1);
    repeat (GAP) tick();
    check("abort_idle_done", busy, 0);

    // list without EOL runs dry: IDLE without list_done
    push_desc(mk(32'h0000_0213, 20));
    push_desc(mk(32'h0000_0213, 21));
    pulse_start();
    tick();
    check_issue("ur_issue0");
    answer_done(3);
    count_low(n);
    check("ur_low_cycles", n, GAP + 1);
    check_issue("ur_issue1");
    answer_done(3);
    repeat (GAP - 1) tick();
    check("ur_gap_busy", busy, 1);
    tick();
    check("ur_idle_busy", busy, 0);
    check("ur_ldone", list_done, 0);
    check("ur_tcount", task_count, 2);

    // start with an empty queue is ignored and keeps task_count
    pulse_start();
    check("empty_start_busy", busy, 0);
    check("empty_start_tcount", task_count, 2);

    // timeout after TMO WAIT cycles
    push_desc(mk(32'h0000_0213, 30));
    pulse_start();
    tick();
    check_issue("tmo_issue");
    repeat (TMO) tick();
    check("tmo_wait_last", timeout_err, 0);
    check("tmo_wait_busy", busy, 1);
    tick();
    check("tmo_err", timeout_err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_en_low", reg_0 & EN_MASK, 0);
    repeat (3) tick();
    check("tmo_sticky", timeout_err, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("tmo_abort_clr", timeout_err, 0);
    check("tmo_abort_idle", busy, 0);

    // reset in WAIT drops everything
    push_desc(mk(32'h0000_0213, 40));
    push_desc(mk(32'h0000_0213, 41));
    pulse_start();
    tick();
    check_issue("rstw_issue");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("rstw_regs", {reg_3, reg_2, reg_1, reg_0}, 0);
    check("rstw_level", fifo_level, 0);
    check("rstw_busy", busy, 0);
    check("rstw_ready", desc_ready, 1);
    check("rstw_tcount", task_count, 0);
    pulse_start();
    check("rstw_start_empty", busy, 0);
    tick();
    check("rstw_still_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
